// File: rtl/ir_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ir_seq_ctrl_pkg
// Shared constants for the instruction-register sequencer.
// - Opcode values (upper nibble of the instruction word). The execute and
//   memory blocks use the same values.
// - State encoding of the sequencer FSM.
// - A small helper that classifies the opcodes with no defined meaning.
// ----------------------------------------------------------------------------
package ir_seq_ctrl_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_LDAB = 4'h3;
    localparam logic [3:0] OP_EXE  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Sequencer states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_WR_A     = 3'd3;
    localparam logic [2:0] S_WR_B     = 3'd4;
    localparam logic [2:0] S_EX_START = 3'd5;
    localparam logic [2:0] S_EX_WAIT  = 3'd6;
    localparam logic [2:0] S_HALT     = 3'd7;

    // Opcodes 6..E are reserved; the sequencer flags them and runs them as NOP.
    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'h6) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/ir_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// ir_seq_ctrl_if
// Instruction-fetch bus between the sequencer and instruction memory.
//   mem_req   : fetch request, held until acknowledged
//   mem_addr  : fetch address (the sequencer's PC)
//   mem_ack   : fetch complete; mem_rdata valid in the same cycle
//   mem_rdata : 16-bit instruction word (also feeds the IR data input)
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface ir_seq_ctrl_if #(
    parameter int PC_W = 8
);
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [15:0]     mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ir_seq_timer.sv
// ----------------------------------------------------------------------------
// ir_seq_timer
// Execute-wait timeout counter.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   clear   : zero the count (wins over enable)
//   enable  : advance the count by one
//   expired : count has reached EXEC_TO-1; never asserted when EXEC_TO is 0
// ----------------------------------------------------------------------------
module ir_seq_timer #(
    parameter int EXEC_TO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    // Only values 0..EXEC_TO-1 are ever compared, so log2(EXEC_TO) bits suffice.
    localparam int TW = (EXEC_TO > 2) ? $clog2(EXEC_TO) : 1;
    localparam logic [TW-1:0] LAST = TW'((EXEC_TO > 0) ? EXEC_TO - 1 : 0);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (EXEC_TO != 0) && (count == LAST);

endmodule

// File: rtl/ir_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ir_seq_ctrl
// Multi-cycle sequencer for the instruction-register datapath: fetches a word
// at PC, strobes the IR load, decodes the opcode, issues the IR-to-A / IR-to-B
// transfer strobes and starts / waits on the execute unit.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   start      : leave IDLE/HALT and fetch at the current PC
//   stop       : return to IDLE at the next instruction boundary
//   bus        : instruction-fetch bus (master side)
//   ir_read    : IR load strobe (same cycle as mem_ack while fetching)
//   ir_write_a : IR-to-A transfer strobe
//   ir_write_b : IR-to-B transfer strobe
//   exec_start : one-cycle execute start pulse
//   exec_done  : execute complete
//   busy       : state is neither IDLE nor HALT
//   halted     : state is HALT
//   err        : sticky illegal-opcode / execute-timeout flag
// ----------------------------------------------------------------------------
module ir_seq_ctrl
    import ir_seq_ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int EXEC_TO = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    ir_seq_ctrl_if.master bus,
    output logic         ir_read,
    output logic         ir_write_a,
    output logic         ir_write_b,
    output logic         exec_start,
    input  logic         exec_done,
    output logic         busy,
    output logic         halted,
    output logic         err
);
    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [2:0]      boundary;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt_q;
    logic [3:0]      op_q;
    logic            timer_expired;
    logic            fetch_done;

    ir_seq_timer #(.EXEC_TO(EXEC_TO)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_EX_START),
        .enable  (state == S_EX_WAIT),
        .expired (timer_expired)
    );

    // The jump target is only the low PC_W bits of the word; the opcode
    // nibble is taken separately, so the bits in between are not needed.
    if (PC_W < 12) begin : g_unused
        logic unused_rdata;
        assign unused_rdata = ^bus.mem_rdata[11:PC_W];
    end

    assign fetch_done = (state == S_FETCH) && bus.mem_ack;

    // stop only matters at the end of an instruction.
    assign boundary = stop ? S_IDLE : S_FETCH;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_FETCH;
            S_FETCH:    if (bus.mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_q)
                    OP_LDA, OP_LDAB: state_nxt = S_WR_A;
                    OP_LDB:          state_nxt = S_WR_B;
                    OP_EXE:          state_nxt = S_EX_START;
                    OP_HALT:         state_nxt = S_HALT;
                    default:         state_nxt = boundary;
                endcase
            end
            S_WR_A:     state_nxt = (op_q == OP_LDAB) ? S_WR_B : boundary;
            S_WR_B:     state_nxt = boundary;
            S_EX_START: state_nxt = S_EX_WAIT;
            S_EX_WAIT:  if (exec_done || timer_expired) state_nxt = boundary;
            S_HALT:     if (start) state_nxt = S_FETCH;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            op_q  <= OP_NOP;
            tgt_q <= '0;
            err   <= 1'b0;
        end else begin
            if (fetch_done) begin
                op_q  <= bus.mem_rdata[15:12];
                tgt_q <= bus.mem_rdata[PC_W-1:0];
                pc    <= pc + 1'b1;
            end
            if (state == S_DECODE && op_q == OP_JMP) begin
                pc <= tgt_q;
            end
            if (state == S_DECODE && op_illegal(op_q)) begin
                err <= 1'b1;
            end
            // exec_done arriving in the last allowed cycle still counts as done.
            if (state == S_EX_WAIT && !exec_done && timer_expired) begin
                err <= 1'b1;
            end
        end
    end

    // mem_req is a pure state decode, so it drops as soon as reset forces IDLE.
    assign bus.mem_req  = (state == S_FETCH);
    assign bus.mem_addr = pc;
    // The IR must capture mem_rdata on the acknowledging edge, hence Mealy.
    assign ir_read      = fetch_done;
    assign ir_write_a   = (state == S_WR_A);
    assign ir_write_b   = (state == S_WR_B);
    assign exec_start   = (state == S_EX_START);
    assign busy         = (state != S_IDLE) && (state != S_HALT);
    assign halted       = (state == S_HALT);

endmodule
